// File: rtl/bf_exec_sequencer.sv
// bf_exec_sequencer: instruction-execution controller that sits downstream of
// the instruction-pointer line. It consumes opcodes, dispatches Brainfuck data
// and I/O operations, and reports loop-zero status back to the instruction line.
// Optional feature macro: STEP_MODE_EN (adds Step input and StepDone output for
// single-step execution; when undefined, execution is free-running under Run).
module bf_exec_sequencer #(
  parameter int OPCODE_WIDTH   = 16,
  parameter int REPEAT_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Run,
  input  logic [OPCODE_WIDTH-1:0] Opcode,
  input  logic                    OpcodeReady,
  output logic                    OpcodeAck,
  output logic                    DataZero,
  input  logic                    DataIsZero,
  output logic [1:0]              DataCmd,
  output logic                    DataReq,
  input  logic                    DataDone,
  output logic                    OutReq,
  input  logic                    OutAck,
  output logic                    InReq,
  input  logic                    InAck,
  output logic                    Halted,
  output logic                    Fault,
  output logic [COUNT_WIDTH-1:0]  InstrCount
`ifdef STEP_MODE_EN
  ,
  input  logic                    Step,
  output logic                    StepDone
`endif
);

  localparam int WD_WIDTH = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    DATA_REQ,
    DATA_WAIT,
    IO_WAIT,
    ACK,
    ACK_WAIT,
    STOP
  } state_t;

  state_t                   state_reg;
  logic [3:0]               op_code_reg;
  logic [REPEAT_WIDTH-1:0]  rpt_cnt_reg;
  logic [WD_WIDTH-1:0]      wd_cnt_reg;
  logic                     ack_reg;
  logic                     data_zero_reg;
  logic [1:0]               data_cmd_reg;
  logic                     data_req_reg;
  logic                     out_req_reg;
  logic                     in_req_reg;
  logic                     halted_reg;
  logic                     fault_reg;
  logic [COUNT_WIDTH-1:0]   instr_count_reg;

  logic [3:0]               op_code;
  logic [REPEAT_WIDTH-1:0]  rpt_field;
  logic [1:0]               cmd_field;
  logic                     step_go;
  logic                     start_ok;
  logic                     io_done;
  logic                     wd_expired;

  assign op_code   = Opcode[3:0];
  assign rpt_field = Opcode[REPEAT_WIDTH+3:4];
  // '+','-','>','<' (codes 1..4) map onto DataCmd 00..11
  assign cmd_field = 2'(op_code - 4'd1);

  // Opcode bits above the repeat field carry no meaning for this block
  generate
    if (OPCODE_WIDTH > REPEAT_WIDTH + 4) begin : g_unused_hi
      logic unused_opcode_hi;
      assign unused_opcode_hi = ^Opcode[OPCODE_WIDTH-1:REPEAT_WIDTH+4];
    end
  endgenerate

`ifdef STEP_MODE_EN
  logic step_prev_reg;

  // Remember the previous Step level so IDLE only leaves on a rising edge
  always_ff @(posedge Clk) begin
    if (Rst) begin
      step_prev_reg <= 1'b0;
    end else begin
      step_prev_reg <= Step;
    end
  end

  assign step_go  = Step & ~step_prev_reg;
  assign StepDone = ack_reg;
`else
  assign step_go = 1'b1;
`endif

  assign start_ok   = Run & OpcodeReady & ~halted_reg & ~fault_reg & step_go;
  assign io_done    = (op_code_reg == 4'd7) ? OutAck : InAck;
  assign wd_expired = (wd_cnt_reg == WD_LAST);

  // Main sequencer: decode, dispatch, watchdog and acknowledge, all outputs registered
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg       <= IDLE;
      op_code_reg     <= '0;
      rpt_cnt_reg     <= '0;
      wd_cnt_reg      <= '0;
      ack_reg         <= 1'b0;
      data_zero_reg   <= 1'b0;
      data_cmd_reg    <= 2'b00;
      data_req_reg    <= 1'b0;
      out_req_reg     <= 1'b0;
      in_req_reg      <= 1'b0;
      halted_reg      <= 1'b0;
      fault_reg       <= 1'b0;
      instr_count_reg <= '0;
    end else begin
      // Pulse outputs default low; only the transitions below raise them
      ack_reg      <= 1'b0;
      data_req_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            state_reg <= DECODE;
          end
        end

        DECODE: begin
          op_code_reg <= op_code;
          rpt_cnt_reg <= rpt_field;
          wd_cnt_reg  <= '0;
          case (op_code)
            4'd1, 4'd2, 4'd3, 4'd4: begin
              data_cmd_reg <= cmd_field;
              data_req_reg <= 1'b1;
              state_reg    <= DATA_REQ;
            end
            4'd5, 4'd6: begin
              // Loop opcodes capture the live zero flag so it is valid during Ack
              data_zero_reg <= DataIsZero;
              ack_reg       <= 1'b1;
              state_reg     <= ACK;
            end
            4'd0: begin
              ack_reg   <= 1'b1;
              state_reg <= ACK;
            end
            4'd7: begin
              out_req_reg <= 1'b1;
              state_reg   <= IO_WAIT;
            end
            4'd8: begin
              in_req_reg <= 1'b1;
              state_reg  <= IO_WAIT;
            end
            4'd9: begin
              halted_reg <= 1'b1;
              ack_reg    <= 1'b1;
              state_reg  <= ACK;
            end
            default: begin
              // Illegal opcode: never acknowledged, the core stops here
              fault_reg <= 1'b1;
              state_reg <= STOP;
            end
          endcase
        end

        DATA_REQ: begin
          wd_cnt_reg <= '0;
          state_reg  <= DATA_WAIT;
        end

        DATA_WAIT: begin
          // Completion is checked first so it wins over a simultaneous timeout
          if (DataDone) begin
            if (rpt_cnt_reg == '0) begin
              ack_reg   <= 1'b1;
              state_reg <= ACK;
            end else begin
              rpt_cnt_reg  <= rpt_cnt_reg - 1'b1;
              data_req_reg <= 1'b1;
              state_reg    <= DATA_REQ;
            end
          end else if (wd_expired) begin
            fault_reg <= 1'b1;
            state_reg <= STOP;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
        end

        IO_WAIT: begin
          if (io_done) begin
            out_req_reg <= 1'b0;
            in_req_reg  <= 1'b0;
            ack_reg     <= 1'b1;
            state_reg   <= ACK;
          end else if (wd_expired) begin
            out_req_reg <= 1'b0;
            in_req_reg  <= 1'b0;
            fault_reg   <= 1'b1;
            state_reg   <= STOP;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
        end

        ACK: begin
          instr_count_reg <= instr_count_reg + 1'b1;
          state_reg       <= ACK_WAIT;
        end

        ACK_WAIT: begin
          // Wait for Ready to fall so the same opcode is never consumed twice
          if (halted_reg) begin
            state_reg <= STOP;
          end else if (!OpcodeReady) begin
            state_reg <= IDLE;
          end
        end

        STOP: begin
          state_reg <= STOP;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign OpcodeAck  = ack_reg;
  assign DataZero   = data_zero_reg;
  assign DataCmd    = data_cmd_reg;
  assign DataReq    = data_req_reg;
  assign OutReq     = out_req_reg;
  assign InReq      = in_req_reg;
  assign Halted     = halted_reg;
  assign Fault      = fault_reg;
  assign InstrCount = instr_count_reg;

endmodule

// File: tb/tb_bf_exec_sequencer.sv
// Self-checking bench for bf_exec_sequencer: the bench acts as instruction line,
// data line and I/O port, and compares against a transaction-level model.
module tb_bf_exec_sequencer;

  logic        Clk = 1'b0;
  logic        Rst, Run, OpcodeReady, DataIsZero, DataDone, OutAck, InAck;
  logic [15:0] Opcode;
  logic        OpcodeAck, DataZero, DataReq, OutReq, InReq, Halted, Fault;
  logic [1:0]  DataCmd;
  logic [15:0] InstrCount;
`ifdef STEP_MODE_EN
  logic        Step, StepDone;
`endif

  bf_exec_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Run(Run),
    .Opcode(Opcode), .OpcodeReady(OpcodeReady), .OpcodeAck(OpcodeAck),
    .DataZero(DataZero), .DataIsZero(DataIsZero),
    .DataCmd(DataCmd), .DataReq(DataReq), .DataDone(DataDone),
    .OutReq(OutReq), .OutAck(OutAck), .InReq(InReq), .InAck(InAck),
    .Halted(Halted), .Fault(Fault), .InstrCount(InstrCount)
`ifdef STEP_MODE_EN
    , .Step(Step), .StepDone(StepDone)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (architectural view only)
  int m_count;
  bit m_dz, m_halted, m_fault;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1; Run = 1'b0; OpcodeReady = 1'b0; Opcode = '0;
    DataIsZero = 1'b0; DataDone = 1'b0; OutAck = 1'b0; InAck = 1'b0;
`ifdef STEP_MODE_EN
    Step = 1'b0;
`endif
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    m_count = 0; m_dz = 0; m_halted = 0; m_fault = 0;
    @(negedge Clk);
  endtask

  // One transaction: present an opcode, serve the data/I/O side, and check.
  // done_dly: cycles from DataReq to DataDone; io_resp=0 means I/O never answers.
  task automatic run_op(input logic [15:0] op, input bit dz_in, input int done_dly,
                        input bit io_resp, input bit chk_lat);
    int  code, r, exp_req, exp_ack, n_req, n_ack, first_req, cyc, dcd, iocd;
    int  out_cyc, in_cyc, drop_at, post;
    bit  accepts, io_started, dropped, ack_dz, exp_fault, exp_out, exp_in;
    logic [1:0] exp_cmd;
    code = int'(op[3:0]);
    r    = int'(op[11:4]);
    accepts   = Run && !m_halted && !m_fault;
    exp_req   = (accepts && code >= 1 && code <= 4) ? r + 1 : 0;
    exp_out   = accepts && code == 7;
    exp_in    = accepts && code == 8;
    exp_fault = m_fault || (accepts && (code > 9 || ((exp_out || exp_in) && !io_resp)));
    exp_ack   = (accepts && !exp_fault) ? 1 : 0;
    exp_cmd   = 2'(code - 1);
    n_req = 0; n_ack = 0; first_req = -1; cyc = 0; dcd = 0; iocd = 0;
    out_cyc = 0; in_cyc = 0; drop_at = 0; post = 0;
    io_started = 0; dropped = 0; ack_dz = 0;

    Opcode = op; DataIsZero = dz_in; OpcodeReady = 1'b1;
`ifdef STEP_MODE_EN
    Step = 1'b1;
`endif
    while (cyc < 400) begin
      @(negedge Clk);
      cyc++;
      DataDone = 1'b0;
      if (dcd > 0) begin
        dcd--;
        if (dcd == 0) DataDone = 1'b1;
      end
      if (DataReq) begin
        n_req++;
        if (first_req < 0) first_req = cyc;
        check("data_cmd", 32'(DataCmd), 32'(exp_cmd));
        dcd = done_dly;
      end
      OutAck = 1'b0; InAck = 1'b0;
      if (iocd > 0) begin
        iocd--;
        if (iocd == 0) begin
          if (code == 7) OutAck = 1'b1; else InAck = 1'b1;
        end
      end
      if (OutReq) out_cyc++;
      if (InReq)  in_cyc++;
      if ((OutReq || InReq) && !io_started && io_resp) begin
        io_started = 1;
        iocd = int'($urandom_range(1, 6));
      end
      if (OpcodeAck) begin
        n_ack++;
        ack_dz  = DataZero;
        drop_at = cyc + int'($urandom_range(0, 3));
      end
      if (n_ack > 0 && !dropped && cyc >= drop_at) begin
        OpcodeReady = 1'b0;
`ifdef STEP_MODE_EN
        Step = 1'b0;
`endif
        dropped = 1;
      end
      if (dropped || Fault) begin
        post++;
        if (post > 5) break;
      end
      if (!accepts && cyc >= 20) break;
    end
    OpcodeReady = 1'b0;
`ifdef STEP_MODE_EN
    Step = 1'b0;
`endif
    DataDone = 1'b0; OutAck = 1'b0; InAck = 1'b0;

    // Advance the model
    if (exp_ack == 1) begin
      m_count = (m_count + 1) & 16'hFFFF;
      if (code == 5 || code == 6) m_dz = dz_in;
      if (code == 9) m_halted = 1;
    end
    m_fault = exp_fault;

    check("data_req_count", 32'(n_req), 32'(exp_req));
    check("ack_count", 32'(n_ack), 32'(exp_ack));
    if (exp_ack == 1) check("ack_datazero", 32'(ack_dz), 32'(m_dz));
    check("instr_count", 32'(InstrCount), 32'(m_count));
    check("halted", 32'(Halted), 32'(m_halted));
    check("fault", 32'(Fault), 32'(m_fault));
    check("out_req_seen", 32'(out_cyc > 0), 32'(exp_out));
    check("in_req_seen", 32'(in_cyc > 0), 32'(exp_in));
    if (chk_lat && exp_req > 0) check("req_latency", 32'(first_req), 32'd2);
    if (exp_out && !io_resp) begin
      check("wd_cycles", 32'(out_cyc), 32'(255));
      check("out_req_after_to", 32'(OutReq), 32'd0);
    end
    $display("op=%h code=%0d R=%0d req=%0d ack=%0d dz=%0b cnt=%0d halt=%0b fault=%0b",
             op, code, r, n_req, n_ack, DataZero, InstrCount, Halted, Fault);
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    int code, r, waited;
    logic [15:0] op;

    do_reset();
    check("reset_outputs",
          32'({OpcodeAck, DataZero, DataCmd, DataReq, OutReq, InReq, Halted, Fault, InstrCount}),
          32'd0);
    Run = 1'b1;

    // '+' with R=3, DataDone two cycles after each request
    run_op(16'h0031, 1'b0, 2, 1'b1, 1'b1);
    // Loop opcodes report the captured zero flag during their Ack
    run_op(16'h0005, 1'b1, 2, 1'b1, 1'b0);
    run_op(16'h0006, 1'b0, 2, 1'b1, 1'b0);

    // Randomized legal opcodes (upper bits and repeat field randomized)
    for (int i = 0; i < 40; i++) begin
      code = int'($urandom_range(0, 8));
      r    = (code >= 1 && code <= 4) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 255));
      op   = {4'($urandom), 8'(r), 4'(code)};
      run_op(op, 1'($urandom), int'($urandom_range(1, 4)), 1'b1, 1'b1);
    end

    // Run low: nothing is consumed
    Run = 1'b0;
    run_op(16'h0001, 1'b0, 1, 1'b1, 1'b0);
    Run = 1'b1;

    // Reset while waiting for DataDone
    Opcode = 16'h0021; OpcodeReady = 1'b1;
`ifdef STEP_MODE_EN
    Step = 1'b1;
`endif
    waited = 0;
    while (!DataReq && waited < 10) begin
      @(negedge Clk);
      waited++;
    end
    check("reach_data_req", 32'(DataReq), 32'd1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("midop_reset_outputs",
          32'({OpcodeAck, DataZero, DataCmd, DataReq, OutReq, InReq, Halted, Fault, InstrCount}),
          32'd0);
    Rst = 1'b0; OpcodeReady = 1'b0;
`ifdef STEP_MODE_EN
    Step = 1'b0;
`endif
    m_count = 0; m_dz = 0; m_halted = 0; m_fault = 0;
    repeat (2) @(negedge Clk);
    run_op(16'h0012, 1'b0, 1, 1'b1, 1'b1);

    // Output handshake never answered: watchdog fault, then reset clears it
    run_op(16'h0007, 1'b0, 1, 1'b0, 1'b0);
    do_reset();
    check("fault_cleared", 32'(Fault), 32'd0);
    check("count_cleared", 32'(InstrCount), 32'd0);
    Run = 1'b1;

    // Illegal opcode
    run_op({8'h00, 4'h0, 4'($urandom_range(10, 15))}, 1'b0, 1, 1'b1, 1'b0);
    do_reset();
    Run = 1'b1;

    // HALT, then further opcodes are ignored
    run_op(16'h0001, 1'b0, 1, 1'b1, 1'b1);
    run_op(16'h0009, 1'b0, 1, 1'b1, 1'b0);
    run_op(16'h0001, 1'b0, 1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
